// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle instruction sequencer (IDLE/FETCH/DECODE/EXECUTE/WRITEBACK/TRAP).
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   -> an illegal opcode in DECODE parks the FSM in TRAP until rst.
//   undefined -> an illegal opcode retires as a NOP (no rf write, no jump).
//
// Fetch handshake: imem_req is high in every FETCH cycle. The fetch completes
// on the first rising edge where imem_req=1 and imem_ready=1. On that edge
// inst_out loads imem_rdata. imem_ready outside FETCH is ignored.
//
// Strobes rf_we/pc_en/pc_sel are combinational from the WRITEBACK state and are
// masked while rst=1, so an instruction cut off by reset never emits a strobe.
module core_ctrl (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  input  logic [6:0]  dec_opcode,
  input  logic        dec_we,
  input  logic        dec_is_jump,
  input  logic        stall,
  output logic        rf_we,
  output logic        pc_en,
  output logic        pc_sel,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] retire_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic        nop_q, nop_d;        // current instruction had an illegal opcode
  logic [31:0] retire_q, retire_d;
  logic        opcode_legal;

  // Legal opcode set: OP, OP-IMM, LUI, JAL, JALR.
  always_comb begin
    opcode_legal = 1'b0;
    case (dec_opcode)
      7'b0110011,
      7'b0010011,
      7'b0110111,
      7'b1101111,
      7'b1100111: opcode_legal = 1'b1;
      default:    opcode_legal = 1'b0;
    endcase
  end

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    inst_d   = inst_q;
    nop_d    = nop_q;
    retire_d = retire_q;
    imem_req = 1'b0;
    rf_we    = 1'b0;
    pc_en    = 1'b0;
    pc_sel   = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          inst_d  = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        nop_d = ~opcode_legal;
`ifdef ILLEGAL_TRAP_EN
        state_d = opcode_legal ? S_EXECUTE : S_TRAP;
`else
        state_d = S_EXECUTE;
`endif
      end
      S_EXECUTE: begin
        if (!stall) state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        if (!rst) begin
          rf_we  = dec_we & ~nop_q;
          pc_en  = 1'b1;
          pc_sel = dec_is_jump & ~nop_q;
        end
        retire_d = retire_q + 32'd1;
        state_d  = S_FETCH;
      end
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        illegal = 1'b1;
        state_d = S_TRAP;
`else
        // Unreachable in this build; recover through IDLE.
        state_d = S_IDLE;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      inst_q   <= 32'd0;
      nop_q    <= 1'b0;
      retire_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      inst_q   <= inst_d;
      nop_q    <= nop_d;
      retire_q <= retire_d;
    end
  end

  assign state        = state_q;
  assign inst_out     = inst_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: directed self-checking bench for core_ctrl.
// The decoder is modelled crudely: dec_we is always 1, and dec_is_jump is set for
// any opcode matching 11x x1xx. As a result, the illegal opcode 0x7F also drives
// both flags high, and the NOP path has to mask them.
module tb_core_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst_out;
  logic [6:0]  dec_opcode;
  logic        dec_we;
  logic        dec_is_jump;
  logic        stall;
  logic        rf_we;
  logic        pc_en;
  logic        pc_sel;
  logic        illegal;
  logic [2:0]  state;
  logic [31:0] retire_count;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Clock and DUT.
  always #5 clk = ~clk;

  core_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .inst_out     (inst_out),
    .dec_opcode   (dec_opcode),
    .dec_we       (dec_we),
    .dec_is_jump  (dec_is_jump),
    .stall        (stall),
    .rf_we        (rf_we),
    .pc_en        (pc_en),
    .pc_sel       (pc_sel),
    .illegal      (illegal),
    .state        (state),
    .retire_count (retire_count)
  );

  // External decoder model fed from the latched instruction.
  assign dec_opcode  = inst_out[6:0];
  assign dec_we      = 1'b1;
  assign dec_is_jump = (inst_out[6:5] == 2'b11) && inst_out[2];

  // Advance one clock edge; sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctl(input logic [2:0] st, input logic req, input logic rfwe,
                                      input logic pcen, input logic pcsel, input logic ill);
    return {24'd0, st, req, rfwe, pcen, pcsel, ill};
  endfunction

  task automatic check_ctl(input string tag, input logic [31:0] exp);
    check(tag, {24'd0, state, imem_req, rf_we, pc_en, pc_sel, illegal}, exp);
  endtask

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  // Directed stimulus.
  initial begin
    rst        = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'h0050_0093;   // addi x1, x0, 5
    stall      = 1'b0;

    // Reset held for two cycles.
    tick();
    tick();
    check_ctl("reset_ctl", ctl(3'd0, 0, 0, 0, 0, 0));
    check("reset_inst", inst_out, 32'd0);
    check("reset_retire", retire_count, 32'd0);

    // Single addi with zero-wait memory: states 1,2,3,4,1.
    rst = 1'b0;
    tick();
    check_ctl("addi_fetch", ctl(3'd1, 1, 0, 0, 0, 0));
    tick();
    check_ctl("addi_decode", ctl(3'd2, 0, 0, 0, 0, 0));
    check("addi_inst", inst_out, 32'h0050_0093);
    tick();
    check_ctl("addi_execute", ctl(3'd3, 0, 0, 0, 0, 0));
    tick();
    check_ctl("addi_wb", ctl(3'd4, 0, 1, 1, 0, 0));
    check("addi_retire_wb", retire_count, 32'd0);
    imem_ready = 1'b0;
    imem_rdata = 32'h0080_006F;   // jal x0, 8
    tick();
    check_ctl("addi_refetch", ctl(3'd1, 1, 0, 0, 0, 0));
    check("addi_retire", retire_count, 32'd1);
    check("wait_inst_c1", inst_out, 32'h0050_0093);

    // Fetch wait: ready low for three cycles, high on the fourth.
    for (int i = 2; i <= 3; i++) begin
      tick();
      check_ctl($sformatf("wait_fetch_c%0d", i), ctl(3'd1, 1, 0, 0, 0, 0));
      check($sformatf("wait_inst_c%0d", i), inst_out, 32'h0050_0093);
    end
    tick();
    check_ctl("wait_fetch_c4", ctl(3'd1, 1, 0, 0, 0, 0));
    check("wait_inst_c4", inst_out, 32'h0050_0093);
    imem_ready = 1'b1;
    tick();
    check_ctl("jal_decode", ctl(3'd2, 0, 0, 0, 0, 0));
    check("jal_inst", inst_out, 32'h0080_006F);

    // Ready/data outside FETCH must be ignored; stall five cycles in EXECUTE.
    imem_rdata = 32'hDEAD_BEEF;
    stall      = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_ctl($sformatf("stall_exec_c%0d", i), ctl(3'd3, 0, 0, 0, 0, 0));
    end
    check("stall_inst_hold", inst_out, 32'h0080_006F);
    tick();
    check_ctl("stall_exec_c6", ctl(3'd3, 0, 0, 0, 0, 0));
    stall = 1'b0;
    tick();
    check_ctl("jal_wb", ctl(3'd4, 0, 1, 1, 1, 0));
    imem_rdata = 32'h0000_007F;   // illegal opcode
    tick();
    check_ctl("jal_refetch", ctl(3'd1, 1, 0, 0, 0, 0));
    check("jal_retire", retire_count, 32'd2);
    tick();
    check_ctl("ill_decode", ctl(3'd2, 0, 0, 0, 0, 0));
    check("ill_inst", inst_out, 32'h0000_007F);
    imem_ready = 1'b0;
    tick();
`ifdef ILLEGAL_TRAP_EN
    check_ctl("ill_trap_c1", ctl(3'd5, 0, 0, 0, 0, 1));
    imem_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      tick();
      check_ctl($sformatf("ill_trap_c%0d", i), ctl(3'd5, 0, 0, 0, 0, 1));
    end
    check("ill_trap_retire", retire_count, 32'd2);
`else
    check_ctl("ill_nop_exec", ctl(3'd3, 0, 0, 0, 0, 0));
    tick();
    check_ctl("ill_nop_wb", ctl(3'd4, 0, 0, 1, 0, 0));
    tick();
    check_ctl("ill_nop_refetch", ctl(3'd1, 1, 0, 0, 0, 0));
    check("ill_nop_retire", retire_count, 32'd3);
`endif

    // Reset from wherever the FSM is.
    rst = 1'b1;
    tick();
    check_ctl("rst1_ctl", ctl(3'd0, 0, 0, 0, 0, 0));
    check("rst1_inst", inst_out, 32'd0);
    check("rst1_retire", retire_count, 32'd0);

    // Reset in the middle of FETCH.
    rst        = 1'b0;
    imem_ready = 1'b0;
    tick();
    check_ctl("midfetch_fetch", ctl(3'd1, 1, 0, 0, 0, 0));
    rst = 1'b1;
    #1;
    check_ctl("midfetch_rst_req", ctl(3'd1, 1, 0, 0, 0, 0));
    tick();
    check_ctl("midfetch_after", ctl(3'd0, 0, 0, 0, 0, 0));

    // Reset during WRITEBACK of an add: no strobes.
    rst        = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'h0000_0033;   // add x0, x0, x0
    tick();
    check_ctl("add_fetch", ctl(3'd1, 1, 0, 0, 0, 0));
    tick();
    check("add_inst", inst_out, 32'h0000_0033);
    tick();
    check_ctl("add_exec", ctl(3'd3, 0, 0, 0, 0, 0));
    tick();
    check_ctl("add_wb", ctl(3'd4, 0, 1, 1, 0, 0));
    rst = 1'b1;
    #1;
    check_ctl("wb_rst_no_strobe", ctl(3'd4, 0, 0, 0, 0, 0));
    tick();
    check_ctl("wb_rst_after", ctl(3'd0, 0, 0, 0, 0, 0));
    check("wb_rst_retire", retire_count, 32'd0);
    check("wb_rst_inst", inst_out, 32'd0);

    // Retire counter wrap using a preloaded value.
    rst        = 1'b0;
    imem_rdata = 32'h0000_00B7;   // lui x1, 0
    tick();
    check_ctl("lui_fetch", ctl(3'd1, 1, 0, 0, 0, 0));
    force dut.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_q;
    #1;
    check("wrap_preload", retire_count, 32'hFFFF_FFFF);
    tick();
    check_ctl("lui_decode", ctl(3'd2, 0, 0, 0, 0, 0));
    tick();
    check_ctl("lui_exec", ctl(3'd3, 0, 0, 0, 0, 0));
    tick();
    check_ctl("lui_wb", ctl(3'd4, 0, 1, 1, 0, 0));
    check("wrap_before", retire_count, 32'hFFFF_FFFF);
    tick();
    check("wrap_after", retire_count, 32'd0);
    check_ctl("lui_refetch", ctl(3'd1, 1, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/core_ctrl.md
CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst; all state updates on the rising edge of clk.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 imem_req  out  1  instruction fetch request to instruction memory at the current PC.
REQ-005 imem_ready  in  1  fetch data valid on imem_rdata this cycle.
REQ-006 imem_rdata  in  32  fetched instruction word.
REQ-007 inst_out  out  32  latched instruction word, driven to the decoder's inst_encoding.
REQ-008 dec_opcode  in  7  decoder opcode field.
REQ-009 dec_we  in  1  decoder write-enable.
REQ-010 dec_is_jump  in  1  decoder JAL/JALR flag.
REQ-011 stall  in  1  execute-stage hold request.
REQ-012 rf_we  out  1  one-cycle register-file write strobe.
REQ-013 pc_en  out  1  one-cycle PC update strobe.
REQ-014 pc_sel  out  1  PC source: 0 = PC+4, 1 = jump target; valid only when pc_en=1.
REQ-015 illegal  out  1  illegal-opcode indicator.
REQ-016 state  out  3  current FSM state, for debug.
REQ-017 retire_count  out  32  count of instructions retired.

Function
REQ-018 The FSM SHALL have the states IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4 and TRAP=5.
REQ-019 In IDLE the FSM SHALL move to FETCH on the next cycle; IDLE is entered only from reset.
REQ-020 In FETCH, imem_req SHALL be 1 until imem_ready=1 is sampled; on that cycle inst_out SHALL load imem_rdata and the FSM SHALL move to DECODE.
REQ-021 imem_ready sampled in any state other than FETCH SHALL be ignored.
REQ-022 DECODE SHALL last exactly one cycle, then move to EXECUTE (legal opcode) or as set by REQ-031/REQ-032.
REQ-023 The legal opcodes SHALL be exactly 0110011, 0010011, 0110111, 1101111 and 1100111.
REQ-024 EXECUTE SHALL hold while stall=1 and move to WRITEBACK on the first cycle with stall=0.
REQ-025 In WRITEBACK, for exactly one cycle: rf_we=dec_we, pc_en=1, pc_sel=dec_is_jump, and retire_count increments by 1; the FSM then moves to FETCH.
REQ-026 retire_count SHALL wrap from 0xFFFFFFFF to 0.
REQ-027 rf_we, pc_en and pc_sel SHALL be 0 in every state other than WRITEBACK.
REQ-028 inst_out SHALL hold its value except on the load cycle defined in REQ-020.
REQ-029 With zero-wait memory and stall=0, one instruction SHALL take 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).

Reset
REQ-030 When rst=1, the block SHALL set state=IDLE and imem_req, inst_out, rf_we, pc_en, pc_sel, illegal and retire_count to 0 at the next edge, regardless of the current state; reset during FETCH drops imem_req on the following cycle, and no strobe is issued for an instruction interrupted mid-operation.

Configuration
REQ-031 With ILLEGAL_TRAP_EN defined, an illegal opcode in DECODE SHALL move the FSM to TRAP; TRAP sets illegal=1, issues no fetch and no strobes, and is left only by rst.
REQ-032 Without ILLEGAL_TRAP_EN, an illegal opcode SHALL be treated as a NOP: normal sequencing, illegal always 0, WRITEBACK with rf_we=0 and pc_sel=0, and retire_count still increments.

Verification
REQ-033 rst held for 2 cycles then released, with imem_ready=1 and imem_rdata=0x00500093 (addi) -> state sequence 0,1,2,3,4,1; rf_we=1 for one cycle; retire_count=1.
REQ-034 imem_ready held 0 for 3 cycles in FETCH -> imem_req=1 for 4 cycles and inst_out unchanged until the ready cycle.
REQ-035 stall=1 for 5 cycles in EXECUTE with JAL 0x0080006F -> EXECUTE lasts 6 cycles, then pc_en=1 with pc_sel=1 for one cycle.
REQ-036 Opcode 0x7F -> with ILLEGAL_TRAP_EN: state=5, illegal=1, imem_req=0 indefinitely; without it: rf_we=0, pc_sel=0, retire_count increments.
REQ-037 rst asserted mid-FETCH and again in WRITEBACK -> all outputs 0 next cycle, and no pc_en pulse.
REQ-038 retire_count preloaded to 0xFFFFFFFF by running instructions or by force, then one retire -> retire_count=0.
